fwd_window_gen: RTL and testbench

FWD_WINDOW_GEN -- requirements
Module: fwd_window_gen

---
 rtl/fwd_window_gen.sv | 131 +++++++++++++
 tb/tb_fwd_window_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_window_gen.sv
// Forward-pass distance window generator.
// Accepts a raster-order binary image, presents the four causal neighbours
// (NW, N, NE, W) of the current pixel to an external min sorter, and emits
// the forward-pass distance of each pixel with one cycle of latency.
module fwd_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_pix,
  output logic [DATA_WIDTH-1:0] nb_a,
  output logic [DATA_WIDTH-1:0] nb_b,
  output logic [DATA_WIDTH-1:0] nb_c,
  output logic [DATA_WIDTH-1:0] nb_d,
  input  logic [DATA_WIDTH-1:0] min_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hist [IMG_W+1];
  logic                  xfer;
  logic                  accept;
  logic                  last_pix;
  logic [DATA_WIDTH-1:0] result;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign accept   = out_valid && out_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  // Neighbour taps with image-border masking; everything reads 0 outside RUN.
  always_comb begin
    logic run, top, left, right;
    run   = (state == S_RUN);
    top   = (row == '0);
    left  = (col == '0);
    right = (col == COL_LAST);
    nb_a  = (run && !top && !left)  ? hist[IMG_W]     : '0;
    nb_b  = (run && !top)           ? hist[IMG_W - 1] : '0;
    nb_c  = (run && !top && !right) ? hist[IMG_W - 2] : '0;
    nb_d  = (run && !left)          ? hist[0]         : '0;
  end

  // Distance of the current pixel: background is 0, object is min+1 saturating.
  always_comb begin
    result = '0;
    if (in_pix) begin
      result = (min_in == '1) ? '1 : min_in + DATA_WIDTH'(1);
    end
  end

  // Control FSM, raster counters and the registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          col <= '0;
          row <= '0;
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (xfer && last_pix) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (accept) begin
            state <= S_IDLE;
            done  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A new transfer overrides the accept, so out_valid stays high on overlap.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Result history; intentionally not reset, row-0 masking hides stale data.
  always_ff @(posedge clk) begin
    if (xfer) begin
      hist[0] <= result;
      for (int unsigned i = 1; i < IMG_W + 1; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fwd_window_gen.sv
// Directed bench for fwd_window_gen: a 4x3 8-bit instance and an 8x8 2-bit
// instance share stimulus; sel picks which one is started and observed.
module tb_fwd_window_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b, start, in_valid, in_pix, out_ready;
  logic sel;

  logic       a_in_ready, a_ov, a_done;
  logic [7:0] a_nb_a, a_nb_b, a_nb_c, a_nb_d, a_min, a_od;
  logic       b_in_ready, b_ov, b_done;
  logic [1:0] b_nb_a, b_nb_b, b_nb_c, b_nb_d, b_min, b_od;
  logic [7:0] b_min8;

  logic       iready, ov, dn;
  logic [7:0] od, nba, nbb, nbc, nbd;

  always #5 clk = ~clk;

  function automatic logic [7:0] min4(input logic [7:0] p, q, r, s);
    logic [7:0] m;
    m = p;
    if (q < m) m = q;
    if (r < m) m = r;
    if (s < m) m = s;
    return m;
  endfunction

  // External min sorters.
  assign a_min  = min4(a_nb_a, a_nb_b, a_nb_c, a_nb_d);
  assign b_min8 = min4({6'b0, b_nb_a}, {6'b0, b_nb_b}, {6'b0, b_nb_c}, {6'b0, b_nb_d});
  assign b_min  = b_min8[1:0];

  fwd_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .reset(rst_a), .start(start & ~sel), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_pix(in_pix),
    .nb_a(a_nb_a), .nb_b(a_nb_b), .nb_c(a_nb_c), .nb_d(a_nb_d),
    .min_in(a_min), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .done(a_done)
  );

  fwd_window_gen #(.DATA_WIDTH(2), .IMG_W(8), .IMG_H(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start & sel), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_pix(in_pix),
    .nb_a(b_nb_a), .nb_b(b_nb_b), .nb_c(b_nb_c), .nb_d(b_nb_d),
    .min_in(b_min), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .done(b_done)
  );

  always_comb begin
    if (sel) begin
      iready = b_in_ready; ov = b_ov; dn = b_done; od = {6'b0, b_od};
      nba = {6'b0, b_nb_a}; nbb = {6'b0, b_nb_b};
      nbc = {6'b0, b_nb_c}; nbd = {6'b0, b_nb_d};
    end else begin
      iready = a_in_ready; ov = a_ov; dn = a_done; od = a_od;
      nba = a_nb_a; nbb = a_nb_b; nbc = a_nb_c; nbd = a_nb_d;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int W, H, N, maxv;
  bit img [64];
  int exp_d [64];
  int e_nw [64], e_n [64], e_ne [64], e_w [64];
  int got [$];

  // Reference forward pass straight from the masking and saturation rules.
  task automatic compute_model();
    int i, m;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        i = r * W + c;
        e_nw[i] = (r > 0 && c > 0)     ? exp_d[i-W-1] : 0;
        e_n[i]  = (r > 0)              ? exp_d[i-W]   : 0;
        e_ne[i] = (r > 0 && c < W - 1) ? exp_d[i-W+1] : 0;
        e_w[i]  = (c > 0)              ? exp_d[i-1]   : 0;
        m = e_nw[i];
        if (e_n[i]  < m) m = e_n[i];
        if (e_ne[i] < m) m = e_ne[i];
        if (e_w[i]  < m) m = e_w[i];
        exp_d[i] = img[i] ? ((m + 1 > maxv) ? maxv : m + 1) : 0;
      end
    end
  endtask

  task automatic setup(input bit s, input int mode);
    sel = s;
    W = s ? 8 : 4;
    H = s ? 8 : 3;
    N = W * H;
    maxv = s ? 3 : 255;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0: img[i] = 1'b0;
        1: img[i] = 1'b1;
        default: img[i] = ((i * 7) % 5) != 2;
      endcase
    end
    compute_model();
  endtask

  // Runs one frame: optional 5-cycle stall, start pulse mid-frame, or reset abort.
  task automatic run_frame(input int stall_from, input int start_at, input int reset_at);
    int idx = 0, done_cnt = 0, after = -1;
    bit hold = 0, restarted = 0, xfer;
    logic [7:0]  hold_d;
    logic [31:0] exp_nb;
    got.delete();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (dn) done_cnt++;
      if (done_cnt > 0) after++;
      if (after >= 3) break;
      if (reset_at >= 0 && idx == reset_at) begin
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %0b expected 0", ov); end
        n_cmp++; if (od !== 8'd0) begin n_err++; $display("FAIL rst_mid_data: got %0d expected 0", od); end
        n_cmp++; if ({nba, nbb, nbc, nbd} !== 32'd0) begin n_err++; $display("FAIL rst_mid_nb: got %h expected 0", {nba, nbb, nbc, nbd}); end
        n_cmp++; if (iready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %0b expected 0", iready); end
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        n_cmp++; if (iready !== 1'b0 || ov !== 1'b0) begin n_err++; $display("FAIL rst_idle_wait: got ready=%0b valid=%0b expected 0/0", iready, ov); end
        return;
      end
      out_ready = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 5);
      in_valid  = (idx < N);
      in_pix    = (idx < N) ? img[idx] : 1'b0;
      if (start_at >= 0 && idx == start_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      #1;
      if (hold) begin
        n_cmp++;
        if (od !== hold_d) begin n_err++; $display("FAIL hold_stable: got %0d expected %0d", od, hold_d); end
      end
      if (ov && !out_ready) begin
        n_cmp++;
        if (iready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %0b expected 0", iready); end
        hold = 1; hold_d = od;
      end else begin
        hold = 0;
      end
      if (ov && out_ready) got.push_back(int'(od));
      if (iready && idx < N) begin
        exp_nb = {8'(e_nw[idx]), 8'(e_n[idx]), 8'(e_ne[idx]), 8'(e_w[idx])};
        n_cmp++;
        if ({nba, nbb, nbc, nbd} !== exp_nb)
          begin n_err++; $display("FAIL nb_pix%0d: got %h expected %h", idx, {nba, nbb, nbc, nbd}, exp_nb); end
      end
      xfer = in_valid && iready;
      @(posedge clk);
      if (xfer) idx++;
    end
    n_cmp++; if (after < 3) begin n_err++; $display("FAIL frame_timeout: got done_cnt %0d expected 1 within budget", done_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL done_pulses: got %0d expected 1", done_cnt); end
    n_cmp++; if (idx != N) begin n_err++; $display("FAIL pix_accepted: got %0d expected %0d", idx, N); end
    n_cmp++; if (got.size() != N) begin n_err++; $display("FAIL out_count: got %0d expected %0d", got.size(), N); end
    for (int i = 0; i < got.size() && i < N; i++) begin
      n_cmp++;
      if (got[i] != exp_d[i]) begin n_err++; $display("FAIL out_pix%0d: got %0d expected %0d", i, got[i], exp_d[i]); end
    end
    #1;
    n_cmp++; if ({nba, nbb, nbc, nbd} !== 32'd0 || iready !== 1'b0)
      begin n_err++; $display("FAIL idle_nb: got nb %h ready %0b expected 0", {nba, nbb, nbc, nbd}, iready); end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_pix = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #3;
      n_cmp++; if (ov !== 1'b0 || dn !== 1'b0) begin n_err++; $display("FAIL reset_flags%0d: got valid %0b done %0b expected 0", s, ov, dn); end
      n_cmp++; if (od !== 8'd0) begin n_err++; $display("FAIL reset_data%0d: got %0d expected 0", s, od); end
      n_cmp++; if (iready !== 1'b0) begin n_err++; $display("FAIL reset_ready%0d: got %0b expected 0", s, iready); end
      n_cmp++; if ({nba, nbb, nbc, nbd} !== 32'd0) begin n_err++; $display("FAIL reset_nb%0d: got %h expected 0", s, {nba, nbb, nbc, nbd}); end
    end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    // Border neighbours read 0, so the right column stays at 1 and
    // row 2 column 2 sees NE = (1,3) = 1.
    int hand [12] = '{1, 1, 1, 1,  1, 2, 2, 1,  1, 2, 2, 1};
    setup(1'b0, 1);
    run_frame(-1, -1, -1);
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] != hand[i]) begin n_err++; $display("FAIL ones_hand%0d: got %0d expected %0d", i, got[i], hand[i]); end
    end
  endtask

  task automatic test_all_zero();
    setup(1'b0, 0);
    run_frame(-1, -1, -1);
  endtask

  task automatic test_backpressure();
    setup(1'b0, 2);
    run_frame(6, -1, -1);
  endtask

  task automatic test_start_ignored();
    setup(1'b0, 2);
    run_frame(-1, 5, -1);
  endtask

  task automatic test_saturation();
    int n_sat = 0, n_zero = 0;
    setup(1'b1, 1);
    run_frame(-1, -1, -1);
    foreach (got[i]) begin
      if (got[i] == 3) n_sat++;
      if (got[i] == 0) n_zero++;
    end
    n_cmp++; if (n_sat == 0) begin n_err++; $display("FAIL sat_reached: got %0d saturated expected >0", n_sat); end
    n_cmp++; if (n_zero != 0) begin n_err++; $display("FAIL sat_wrap: got %0d zeros expected 0", n_zero); end
  endtask

  task automatic test_reset_midframe();
    setup(1'b1, 2);
    run_frame(-1, -1, 13);
    run_frame(-1, -1, -1);
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_all_ones();
    test_all_zero();
    test_backpressure();
    test_start_ignored();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
